// File: rtl/updown_seq_pkg.sv
// Shared encodings and defaults for the up/down sequencing controller.
package updown_seq_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int REP_W_DEF = 4;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PP   = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

endpackage

// File: rtl/updown_seq_if.sv
// Command handshake bundle between a host/register block and the sequencer.
interface updown_seq_if #(
  parameter int WIDTH = updown_seq_pkg::WIDTH_DEF,
  parameter int REP_W = updown_seq_pkg::REP_W_DEF
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [WIDTH-1:0] cmd_lo;
  logic [WIDTH-1:0] cmd_hi;
  logic [REP_W-1:0] cmd_reps;

  modport master (output cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_reps, input cmd_ready);
  modport slave  (input cmd_valid, cmd_mode, cmd_lo, cmd_hi, cmd_reps, output cmd_ready);
endinterface

// File: rtl/updown_count_core.sv
// Count/direction registers with load, step and dir-set controls plus window-edge flags.
module updown_count_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             step_up,
  input  logic             dir_set,
  input  logic             dir_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             at_lo,
  output logic             at_hi
);
  logic [WIDTH-1:0] count_reg;
  logic             dir_reg;

  // Load wins over step so wrap/bounce values override the plain increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      dir_reg   <= 1'b1;
    end else begin
      if (load)
        count_reg <= load_val;
      else if (step)
        count_reg <= step_up ? count_reg + 1'b1 : count_reg - 1'b1;
      if (dir_set)
        dir_reg <= dir_val;
    end
  end

  assign count = count_reg;
  assign dir   = dir_reg;
  assign at_lo = (count_reg == lo);
  assign at_hi = (count_reg == hi);
endmodule

// File: rtl/updown_seq_ctrl.sv
// Sequencer FSM: accepts one command, walks the count through [lo..hi] for a number of passes.
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  updown_seq_if.slave      cmd,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_t           state_reg;
  logic [1:0]       mode_reg;
  logic [WIDTH-1:0] lo_reg, hi_reg;
  logic [REP_W-1:0] reps_reg, passes_reg;
  logic             busy_reg, done_reg, err_reg;

  logic             accept, cmd_bad, terminal, last_pass, wrap;
  logic             load, step, step_up, dir_set, dir_val, at_lo, at_hi;
  logic [WIDTH-1:0] load_val;

  assign cmd.cmd_ready = (state_reg == IDLE);
  assign accept        = cmd.cmd_valid && (state_reg == IDLE);
  assign cmd_bad       = (cmd.cmd_mode == MODE_ILL) || (cmd.cmd_lo > cmd.cmd_hi);
  assign last_pass     = (passes_reg == REP_W'(1));

  always_comb begin
    terminal = 1'b0;
    case (mode_reg)
      MODE_UP:   terminal = at_hi;
      MODE_DOWN: terminal = at_lo;
      MODE_PP:   terminal = at_lo && !dir;
      default:   terminal = 1'b0;
    endcase
  end

  // Core controls; wrap marks the end of one pass (wrap-around or low-end bounce).
  always_comb begin
    load     = 1'b0;
    load_val = count;
    step     = 1'b0;
    step_up  = 1'b1;
    dir_set  = 1'b0;
    dir_val  = 1'b1;
    wrap     = 1'b0;
    if (state_reg == IDLE) begin
      if (accept && !cmd_bad) begin
        load    = 1'b1;
        dir_set = 1'b1;
        if (cmd.cmd_mode == MODE_DOWN) begin
          load_val = cmd.cmd_hi;
          dir_val  = 1'b0;
        end else begin
          load_val = cmd.cmd_lo;
          dir_val  = 1'b1;
        end
      end
    end else if (!abort && !(terminal && last_pass)) begin
      case (mode_reg)
        MODE_UP: begin
          if (at_hi) begin
            load = 1'b1; load_val = lo_reg; wrap = 1'b1;
          end else step = 1'b1;
        end
        MODE_DOWN: begin
          if (at_lo) begin
            load = 1'b1; load_val = hi_reg; wrap = 1'b1;
          end else begin
            step = 1'b1; step_up = 1'b0;
          end
        end
        MODE_PP: begin
          if (dir) begin
            if (at_hi) begin
              load = 1'b1; load_val = hi_reg - 1'b1; dir_set = 1'b1; dir_val = 1'b0;
            end else step = 1'b1;
          end else if (at_lo) begin
            load = 1'b1; load_val = lo_reg + 1'b1; dir_set = 1'b1; dir_val = 1'b1; wrap = 1'b1;
          end else begin
            step = 1'b1; step_up = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      mode_reg   <= '0;
      lo_reg     <= '0;
      hi_reg     <= '0;
      reps_reg   <= '0;
      passes_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (cmd_bad) begin
              err_reg <= 1'b1;
            end else begin
              state_reg  <= RUN;
              busy_reg   <= 1'b1;
              // A single-value ping-pong window never turns around, so run it as up-wrap.
              mode_reg   <= (cmd.cmd_mode == MODE_PP && cmd.cmd_lo == cmd.cmd_hi) ? MODE_UP : cmd.cmd_mode;
              lo_reg     <= cmd.cmd_lo;
              hi_reg     <= cmd.cmd_hi;
              reps_reg   <= cmd.cmd_reps;
              passes_reg <= cmd.cmd_reps;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (terminal && last_pass) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else if (wrap && reps_reg != '0) begin
            passes_reg <= passes_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  updown_count_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .step_up  (step_up),
    .dir_set  (dir_set),
    .dir_val  (dir_val),
    .lo       (lo_reg),
    .hi       (hi_reg),
    .count    (count),
    .dir      (dir),
    .at_lo    (at_lo),
    .at_hi    (at_hi)
  );

  assign busy = busy_reg;
  assign done = done_reg;
  assign err  = err_reg;
endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Self-checking bench: directed and random commands checked against a queue-based sequence model.
module tb_updown_seq_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       abort;
  logic [3:0] count;
  logic       dir, busy, done, err;

  updown_seq_if #(.WIDTH(4), .REP_W(4)) cmd_if ();

  updown_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd_if),
    .abort (abort),
    .count (count),
    .dir   (dir),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [3:0] m_count;
  logic       m_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_dir"}, dir, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ready"}, cmd_if.cmd_ready, 1);
  endtask

  // Expected (count,dir) after each edge from accept onward; done follows the last entry.
  task automatic run_cmd(input logic [1:0] m, input logic [3:0] l, input logic [3:0] h,
                         input logic [3:0] r, input int abort_at, input int reset_at, input bit hold);
    int qc[$];
    int qd[$];
    int ll, hh, passes, k, ab;
    bit legal;
    logic [1:0] em;
    ll = int'(l);
    hh = int'(h);
    legal = (m != 2'b11) && (ll <= hh);
    em = (m == 2'b10 && ll == hh) ? 2'b00 : m;
    passes = (r == 0) ? 40 : int'(r);
    ab = (r == 0 && abort_at < 0) ? 20 : abort_at;
    if (legal) begin
      case (em)
        2'b00: for (int p = 0; p < passes; p++)
                 for (int v = ll; v <= hh; v++) begin qc.push_back(v); qd.push_back(1); end
        2'b01: for (int p = 0; p < passes; p++)
                 for (int v = hh; v >= ll; v--) begin qc.push_back(v); qd.push_back(0); end
        default: begin
          qc.push_back(ll); qd.push_back(1);
          for (int p = 0; p < passes; p++) begin
            for (int v = ll + 1; v <= hh; v++) begin qc.push_back(v); qd.push_back(1); end
            for (int v = hh - 1; v >= ll; v--) begin qc.push_back(v); qd.push_back(0); end
          end
        end
      endcase
    end
    $display("cmd mode=%0d lo=%0d hi=%0d reps=%0d abort_at=%0d reset_at=%0d hold=%0d steps=%0d",
             m, l, h, r, ab, reset_at, hold, qc.size());
    check("ready_idle", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = m;
    cmd_if.cmd_lo    = l;
    cmd_if.cmd_hi    = h;
    cmd_if.cmd_reps  = r;
    tick;
    if (!legal) begin
      cmd_if.cmd_valid = 1'b0;
      check("ill_err", err, 1);
      check("ill_busy", busy, 0);
      check("ill_count", count, m_count);
      check("ill_dir", dir, m_dir);
      tick;
      check("ill_err_clear", err, 0);
      check("ill_busy2", busy, 0);
      return;
    end
    if (!hold) cmd_if.cmd_valid = 1'b0;
    k = 0;
    forever begin
      if (hold) begin
        cmd_if.cmd_mode = 2'($urandom);
        cmd_if.cmd_lo   = 4'($urandom);
        cmd_if.cmd_hi   = 4'($urandom);
        cmd_if.cmd_reps = 4'($urandom);
        check("run_ready", cmd_if.cmd_ready, 0);
      end
      check("run_count", count, qc[k]);
      check("run_dir", dir, qd[k]);
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      if (k == reset_at) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        check_reset_state("midreset");
        m_count = 0; m_dir = 1'b1;
        tick;
        check("midreset_nodone", done, 0);
        check("midreset_busy", busy, 0);
        return;
      end
      if (k == ab) begin
        abort = 1'b1;
        tick;
        abort = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_count", count, qc[k]);
        check("abort_dir", dir, qd[k]);
        m_count = 4'(qc[k]); m_dir = qd[k][0];
        tick;
        check("abort_nodone", done, 0);
        check("abort_busy2", busy, 0);
        return;
      end
      if (k == qc.size() - 1) begin
        tick;
        cmd_if.cmd_valid = 1'b0;
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_ready", cmd_if.cmd_ready, 1);
        check("fin_count", count, qc[k]);
        check("fin_dir", dir, qd[k]);
        m_count = 4'(qc[k]); m_dir = qd[k][0];
        tick;
        check("fin_done_clear", done, 0);
        check("fin_busy2", busy, 0);
        return;
      end
      tick;
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rm;
    logic [3:0] rl, rh, rr, tmp;
    int ra, rs;
    reset = 1'b1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_lo    = 4'd0;
    cmd_if.cmd_hi    = 4'd0;
    cmd_if.cmd_reps  = 4'd0;
    tick;
    tick;
    check_reset_state("reset");
    reset = 1'b0;
    m_count = 0; m_dir = 1'b1;

    run_cmd(2'b00, 4'd2, 4'd5, 4'd2, -1, -1, 1'b0);
    run_cmd(2'b01, 4'd0, 4'd15, 4'd1, -1, -1, 1'b0);
    run_cmd(2'b10, 4'd1, 4'd3, 4'd2, -1, -1, 1'b1);
    run_cmd(2'b00, 4'd7, 4'd3, 4'd1, -1, -1, 1'b0);
    run_cmd(2'b11, 4'd0, 4'd0, 4'd1, -1, -1, 1'b0);
    run_cmd(2'b00, 4'd14, 4'd15, 4'd0, 3, -1, 1'b0);
    run_cmd(2'b00, 4'd4, 4'd8, 4'd1, 4, -1, 1'b0);
    run_cmd(2'b10, 4'd3, 4'd9, 4'd2, -1, 7, 1'b0);

    // Reset on the same edge as a valid command: nothing is accepted.
    reset = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_mode  = 2'b00;
    cmd_if.cmd_lo    = 4'd1;
    cmd_if.cmd_hi    = 4'd4;
    cmd_if.cmd_reps  = 4'd1;
    tick;
    reset = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    $display("cmd reset_with_valid lo=1 hi=4");
    check_reset_state("rstvalid");
    tick;
    check("rstvalid_busy2", busy, 0);
    check("rstvalid_count2", count, 0);
    m_count = 0; m_dir = 1'b1;

    run_cmd(2'b00, 4'd9, 4'd9, 4'd3, -1, -1, 1'b0);
    run_cmd(2'b10, 4'd6, 4'd6, 4'd2, -1, -1, 1'b0);
    run_cmd(2'b10, 4'd0, 4'd15, 4'd1, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rm = 2'($urandom_range(0, 3));
      rl = 4'($urandom);
      rh = 4'($urandom);
      if ($urandom_range(0, 3) != 0 && rl > rh) begin
        tmp = rl; rl = rh; rh = tmp;
      end
      rr = 4'($urandom_range(0, 3));
      if (rr == 0) ra = $urandom_range(0, 30);
      else ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
      rs = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_cmd(rm, rl, rh, rr, ra, rs, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
